move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler.sv | 158 +++++++++++++++
 tb/tb_move_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// Snake tick scheduler: paces movement ticks from score and sequences
// direction latch, head calc, collision check and body/score update.
module move_scheduler #(
    parameter int BASE_DIV = 500000,
    parameter int MIN_DIV  = 100000,
    parameter int STEP     = 20000,
    parameter int DIV_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_state,
    input  logic [6:0] score,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic       check_done,
    input  logic       check_hit,
    input  logic       food_hit,
    output logic [1:0] cur_dir,
    output logic       dir_latch_en,
    output logic       head_calc_en,
    output logic       check_start,
    output logic       body_shift,
    output logic       body_grow,
    output logic       score_inc,
    output logic       collision_detect,
    output logic       tick_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_LATCH, S_CALC, S_CHECK, S_UPDATE
    } state_t;

    localparam int PW = DIV_W + 8;
    localparam logic [1:0] RIGHT = 2'd1;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [1:0]       pend, pend_n, cur_n;
    logic             run;
    logic [PW-1:0]    red, period_w;
    logic [DIV_W-1:0] period;
    logic latch_n, calc_n, start_n, shift_n, grow_n, inc_n, coll_n, busy_n;

    assign run = (game_state == 2'd1);

    // Clamp before subtracting so the period never underflows.
    always_comb begin
        red = PW'(STEP) * PW'(score >> 2);
        if (red + PW'(MIN_DIV) >= PW'(BASE_DIV))
            period_w = PW'(MIN_DIV);
        else
            period_w = PW'(BASE_DIV) - red;
        period = period_w[DIV_W-1:0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur_dir;
        pend_n  = pend;
        shift_n = 1'b0;
        grow_n  = 1'b0;
        inc_n   = 1'b0;
        coll_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_n = S_WAIT;
                    cnt_n   = period;
                    cur_n   = RIGHT;
                    pend_n  = RIGHT;
                end
            end
            S_WAIT: begin
                if (cnt <= DIV_W'(1)) begin
                    state_n = S_LATCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
            S_LATCH: begin
                cur_n   = pend;
                state_n = S_CALC;
            end
            S_CALC: state_n = S_CHECK;
            S_CHECK: begin
                if (check_done) begin
                    if (check_hit) begin
                        state_n = S_IDLE;
                        coll_n  = 1'b1;
                    end else begin
                        state_n = S_UPDATE;
                        grow_n  = food_hit;
                        shift_n = !food_hit;
                        inc_n   = food_hit && (score < 7'd99);
                    end
                end
            end
            S_UPDATE: begin
                cnt_n   = period;
                state_n = S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase

        if (dir_valid && state != S_IDLE && state != S_LATCH &&
            dir_req != (cur_dir ^ 2'd2))
            pend_n = dir_req;

        // Leaving RUN wins over everything, including a pending check result.
        if (state != S_IDLE && !run) begin
            state_n = S_IDLE;
            cur_n   = cur_dir;
            shift_n = 1'b0;
            grow_n  = 1'b0;
            inc_n   = 1'b0;
            coll_n  = 1'b0;
        end

        latch_n = (state_n == S_LATCH);
        calc_n  = (state_n == S_CALC);
        start_n = (state_n == S_CHECK) && (state == S_CALC);
        busy_n  = (state_n == S_LATCH) || (state_n == S_CALC) ||
                  (state_n == S_CHECK) || (state_n == S_UPDATE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            cur_dir          <= RIGHT;
            pend             <= RIGHT;
            dir_latch_en     <= 1'b0;
            head_calc_en     <= 1'b0;
            check_start      <= 1'b0;
            body_shift       <= 1'b0;
            body_grow        <= 1'b0;
            score_inc        <= 1'b0;
            collision_detect <= 1'b0;
            tick_busy        <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            cur_dir          <= cur_n;
            pend             <= pend_n;
            dir_latch_en     <= latch_n;
            head_calc_en     <= calc_n;
            check_start      <= start_n;
            body_shift       <= shift_n;
            body_grow        <= grow_n;
            score_inc        <= inc_n;
            collision_detect <= coll_n;
            tick_busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: expectations are queued when a step
// is driven and popped as the DUT responds.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_state;
    logic [6:0] score;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic       check_done, check_hit, food_hit;
    logic [1:0] cur_dir;
    logic       dir_latch_en, head_calc_en, check_start;
    logic       body_shift, body_grow, score_inc;
    logic       collision_detect, tick_busy;

    int    checks = 0;
    int    errors = 0;
    string tag_q[$];
    int    exp_q[$];

    move_scheduler #(
        .BASE_DIV(40), .MIN_DIV(16), .STEP(4), .DIV_W(20)
    ) dut (
        .clk(clk), .reset(reset), .game_state(game_state),
        .score(score), .dir_valid(dir_valid), .dir_req(dir_req),
        .check_done(check_done), .check_hit(check_hit),
        .food_hit(food_hit), .cur_dir(cur_dir),
        .dir_latch_en(dir_latch_en), .head_calc_en(head_calc_en),
        .check_start(check_start), .body_shift(body_shift),
        .body_grow(body_grow), .score_inc(score_inc),
        .collision_detect(collision_detect), .tick_busy(tick_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // {latch, calc, start, shift, grow, inc, coll, busy}
    function automatic int out_vec();
        return int'({dir_latch_en, head_calc_en, check_start, body_shift,
                     body_grow, score_inc, collision_detect, tick_busy});
    endfunction

    task automatic expect_val(input string t, input int v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic observe(input int obs);
        string t;
        int    e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %0d", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dir_latch_en && n < 200);
        if (!dir_latch_en) n = -1;
    endtask

    // Called right after the negedge that requests RUN (or mid WAIT_TICK).
    task automatic run_tick(input int lat, input int dly, input logic hit,
                            input logic food, input int outc,
                            input int dir);
        int n;
        if (lat >= 0) expect_val("latency", lat);
        expect_val("head_calc", 1);
        expect_val("cur_dir", dir);
        expect_val("check_start", 1);
        if (dly > 0) expect_val("check_start_once", 0);
        expect_val("outcome", outc);
        expect_val("pulse_end", 0);
        wait_latch(n);
        if (lat >= 0) observe(n);
        @(negedge clk);
        observe(int'(head_calc_en));
        observe(int'(cur_dir));
        @(negedge clk);
        observe(int'(check_start));
        if (dly > 0) begin
            @(negedge clk);
            observe(int'(check_start));
            repeat (dly - 1) @(negedge clk);
        end
        check_done = 1'b1;
        check_hit  = hit;
        food_hit   = food;
        @(negedge clk);
        check_done = 1'b0;
        check_hit  = 1'b0;
        food_hit   = 1'b0;
        observe(out_vec());
        @(negedge clk);
        observe(out_vec() >> 2);
    endtask

    task automatic go_idle();
        game_state = 2'd0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        reset      = 1'b1;
        game_state = 2'd0;
        score      = '0;
        dir_valid  = 1'b0;
        dir_req    = 2'd0;
        check_done = 1'b0;
        check_hit  = 1'b0;
        food_hit   = 1'b0;
        expect_val("reset_dir", 1);
        expect_val("reset_outs", 0);
        repeat (2) @(negedge clk);
        observe(int'(cur_dir));
        observe(out_vec());
        reset = 1'b0;
        @(negedge clk);

        // score 0: period 40, plain move
        score = 7'd0; game_state = 2'd1;
        run_tick(41, 0, 1'b0, 1'b0, 8'b0001_0001, 1);
        go_idle();

        // score 20: period 20, eat food, score increments
        score = 7'd20; game_state = 2'd1;
        run_tick(21, 0, 1'b0, 1'b1, 8'b0000_1101, 1);
        go_idle();

        // score 60: period clamps at 16
        score = 7'd60; game_state = 2'd1;
        run_tick(17, 0, 1'b0, 1'b0, 8'b0001_0001, 1);
        go_idle();

        // score 99: grow but no score increment
        score = 7'd99; game_state = 2'd1;
        run_tick(17, 0, 1'b0, 1'b1, 8'b0000_1001, 1);
        go_idle();

        // LEFT alone is a reversal of RIGHT and is dropped
        score = 7'd60; game_state = 2'd1;
        @(negedge clk);
        dir_valid = 1'b1; dir_req = 2'd3;
        @(negedge clk);
        dir_valid = 1'b0;
        run_tick(-1, 0, 1'b0, 1'b0, 8'b0001_0001, 1);
        go_idle();

        // LEFT then UP: UP wins
        game_state = 2'd1;
        @(negedge clk);
        dir_valid = 1'b1; dir_req = 2'd3;
        @(negedge clk);
        dir_req = 2'd0;
        @(negedge clk);
        dir_valid = 1'b0;
        run_tick(-1, 0, 1'b0, 1'b0, 8'b0001_0001, 0);

        // reset in WAIT_TICK clears outputs at once
        repeat (3) @(negedge clk);
        expect_val("async_rst_dir", 1);
        expect_val("async_rst_outs", 0);
        expect_val("post_rst_quiet", 0);
        #1 reset = 1'b1;
        game_state = 2'd0;
        #1;
        observe(int'(cur_dir));
        observe(out_vec());
        @(negedge clk);
        reset = 1'b0;
        acc = 0;
        repeat (60) begin
            @(negedge clk);
            acc |= out_vec();
        end
        observe(acc);

        // delayed collision with food: single pulse, back to IDLE
        score = 7'd60; game_state = 2'd1;
        run_tick(17, 5, 1'b1, 1'b1, 8'b0000_0010, 1);
        game_state = 2'd2;
        expect_val("after_coll_quiet", 0);
        acc = 0;
        repeat (30) begin
            @(negedge clk);
            acc |= out_vec();
        end
        observe(acc);

        // leave RUN in the same cycle check_done arrives
        game_state = 2'd1;
        expect_val("abort_start", 1);
        expect_val("abort_quiet", 0);
        begin
            int n;
            wait_latch(n);
        end
        repeat (2) @(negedge clk);
        observe(int'(check_start));
        game_state = 2'd2;
        check_done = 1'b1;
        food_hit   = 1'b1;
        acc = 0;
        repeat (30) begin
            @(negedge clk);
            check_done = 1'b0;
            food_hit   = 1'b0;
            acc |= out_vec();
        end
        observe(acc);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover count %0d", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
